// File: rtl/shift_left_pipe.sv
// ============================================================================
// Module   : shift_left_pipe
// Summary  : Pipelined log-stage left shifter with a valid/ready handshake.
//            Stage k shifts by 2^k. Define SHL_ROTATE_EN to add rotate-left
//            support through the in_rot port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_left_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STAGES-1:0] in_shamt,
`ifdef SHL_ROTATE_EN
    input  logic              in_rot,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
);

    // Each slot carries the shift amount pre-shifted so that the bit it
    // consumes next always sits at position 0.
    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_data  [STAGES];
    logic [STAGES-1:0] r_shamt [STAGES];

    logic [STAGES-1:0] w_ready;
    logic [STAGES-1:0] w_v_in;
    logic [WIDTH-1:0]  w_d_in   [STAGES];
    logic [STAGES-1:0] w_sh_in  [STAGES];
    logic [WIDTH-1:0]  w_d_next [STAGES];

`ifdef SHL_ROTATE_EN
    logic [STAGES-1:0] r_rot;
    logic [STAGES-1:0] w_rot_in;
`endif

    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input logic             rot,
        input int               k
    );
        logic [WIDTH-1:0] s;
        s = d << (1 << k);
        if (rot) begin
            s = s | (d >> (WIDTH - (1 << k)));
        end
        return en ? s : d;
    endfunction

    // Ready ripples back from the sink; a slot may load if it is empty or
    // its successor is taking its current contents.
    always_comb begin
        w_ready[STAGES-1] = !r_v[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_ready[k] = !r_v[k] || w_ready[k+1];
        end
    end

    always_comb begin
        w_v_in[0]  = in_valid;
        w_d_in[0]  = in_data;
        w_sh_in[0] = in_shamt;
`ifdef SHL_ROTATE_EN
        w_rot_in[0] = in_rot;
`endif
        for (int k = 1; k < STAGES; k++) begin
            w_v_in[k]  = r_v[k-1];
            w_d_in[k]  = r_data[k-1];
            w_sh_in[k] = r_shamt[k-1];
`ifdef SHL_ROTATE_EN
            w_rot_in[k] = r_rot[k-1];
`endif
        end
        for (int k = 0; k < STAGES; k++) begin
`ifdef SHL_ROTATE_EN
            w_d_next[k] = stage_shift(w_d_in[k], w_sh_in[k][0], w_rot_in[k], k);
`else
            w_d_next[k] = stage_shift(w_d_in[k], w_sh_in[k][0], 1'b0, k);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    r_v[k] <= w_v_in[k];
                end
            end
        end
    end

    // Payload registers are not reset; they are qualified by r_v.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (w_ready[k]) begin
                r_data[k]  <= w_d_next[k];
                r_shamt[k] <= w_sh_in[k] >> 1;
`ifdef SHL_ROTATE_EN
                r_rot[k]   <= w_rot_in[k];
`endif
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_v[STAGES-1];
    assign out_data  = r_data[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_shift_left_pipe.sv
// ============================================================================
// Module   : tb_shift_left_pipe
// Summary  : Scoreboard bench for shift_left_pipe (rotate cases need
//            SHL_ROTATE_EN defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_shift_left_pipe;

    localparam int WIDTH  = 64;
    localparam int STAGES = 6;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b1;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  in_data   = '0;
    logic [WIDTH-1:0]  out_data;
    logic [STAGES-1:0] in_shamt  = '0;
`ifdef SHL_ROTATE_EN
    logic              in_rot    = 1'b0;
`endif

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_out    = 0;
    int acc_cyc  = 0;
    int last_out_cyc = 0;
    logic [WIDTH-1:0] exp_q [$];

    shift_left_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
`ifdef SHL_ROTATE_EN
        .in_rot    (in_rot),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output side of the scoreboard: sampled late in the low phase.
    always begin
        @(negedge clk);
        #4;
        if (!rst && out_valid === 1'b1 && out_ready) begin
            n_out++;
            last_out_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h with no operand pending", out_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", out_data, e);
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] ref_shl(input logic [WIDTH-1:0] d, input int s, input bit rot);
        logic [2*WIDTH-1:0] t;
        t = {{WIDTH{1'b0}}, d} << s;
        return rot ? (t[WIDTH-1:0] | t[2*WIDTH-1:WIDTH]) : t[WIDTH-1:0];
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [WIDTH-1:0] d, input logic [STAGES-1:0] s,
                        input bit r, input logic [WIDTH-1:0] e);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
`ifdef SHL_ROTATE_EN
        in_rot   = r;
`endif
        #3;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            #3;
            budget++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end else begin
            exp_q.push_back(e);
            acc_cyc = cyc;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int b;
        b = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && b < 60) begin
            @(negedge clk);
            b++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int n0;
        n0 = n_out;
        out_ready = 1'b1;
        send(64'h1, 6'd1, 1'b0, 64'h2);
        drain();
        checks++;
        if (n_out - n0 != 1 || last_out_cyc - acc_cyc != STAGES) begin
            errors++;
            $display("FAIL latency: outputs %0d latency %0d required 1 and %0d",
                     n_out - n0, last_out_cyc - acc_cyc, STAGES);
        end
    endtask

    task automatic test_boundary();
        send(64'hDEADBEEF_CAFEF00D, 6'd0,  1'b0, 64'hDEADBEEF_CAFEF00D);
        send(64'h1,                 6'd63, 1'b0, 64'h8000_0000_0000_0000);
        send(64'hF000_0000_0000_000F, 6'd4, 1'b0, 64'h0000_0000_0000_00F0);
        drain();
    endtask

`ifdef SHL_ROTATE_EN
    task automatic test_rotate();
        send(64'h8000_0000_0000_0001, 6'd1,  1'b1, 64'h3);
        send(64'h8000_0000_0000_0001, 6'd1,  1'b0, 64'h2);
        send(64'h2,                   6'd63, 1'b1, 64'h1);
        drain();
    endtask
`endif

    task automatic test_backpressure();
        logic [WIDTH-1:0] od [8];
        int idx;
        int n0;
        int b;
        n0 = n_out;
        for (int i = 0; i < 8; i++) od[i] = {$urandom, $urandom};
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            in_data  = od[idx];
            in_shamt = 6'(idx * 7 + 3);
            #3;
            if (in_ready === 1'b1) begin
                exp_q.push_back(ref_shl(od[idx], idx * 7 + 3, 1'b0));
                idx++;
            end
            @(negedge clk);
        end
        checks++;
        if (idx != STAGES || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_capacity: accepted %0d in_ready %b required %0d and 0", idx, in_ready, STAGES);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_full_passthrough: in_ready %b required 1", in_ready);
        end
        #2;
        b = 0;
        while (idx < 8 && b < 30) begin
            in_valid = 1'b1;
            in_data  = od[idx];
            in_shamt = 6'(idx * 7 + 3);
            #3;
            if (in_ready === 1'b1) begin
                exp_q.push_back(ref_shl(od[idx], idx * 7 + 3, 1'b0));
                idx++;
            end
            @(negedge clk);
            b++;
        end
        drain();
        checks++;
        if (n_out - n0 != 8) begin
            errors++;
            $display("FAIL bp_count: outputs %0d required 8", n_out - n0);
        end
    endtask

    task automatic test_back_to_back();
        int first_acc;
        int n0;
        n0 = n_out;
        out_ready = 1'b1;
        first_acc = 0;
        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] d;
            int s;
            d = {$urandom, $urandom};
            s = $urandom_range(0, 63);
            send(d, 6'(s), 1'b0, ref_shl(d, s, 1'b0));
            if (i == 0) first_acc = acc_cyc;
        end
        drain();
        checks++;
        if (n_out - n0 != 20 || last_out_cyc - first_acc != 19 + STAGES) begin
            errors++;
            $display("FAIL stream_rate: outputs %0d span %0d required 20 and %0d",
                     n_out - n0, last_out_cyc - first_acc, 19 + STAGES);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        out_ready = 1'b1;
        send(64'h11, 6'd2, 1'b0, 64'h44);
        send(64'h22, 6'd3, 1'b0, 64'h110);
        send(64'h33, 6'd4, 1'b0, 64'h330);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: out_valid %b in_ready %b required 0 and 1", out_valid, in_ready);
        end
        @(negedge clk);
        n0 = n_out;
        repeat (12) @(negedge clk);
        checks++;
        if (n_out != n0) begin
            errors++;
            $display("FAIL mid_reset_stale: %0d results after reset required 0", n_out - n0);
        end
        send(64'h5, 6'd8, 1'b0, 64'h500);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_boundary();
`ifdef SHL_ROTATE_EN
        test_rotate();
`endif
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
